// File: rtl/fetch_stage.sv
// fetch_stage: RV32I front end. Owns the PC and the IF/ID register, drives the
// instruction-memory address and obeys the hazard unit's stall handshake.
// Optional feature macro: PERF_CNT_EN builds saturating stall/redirect counters;
// without it stall_cnt and flush_cnt are tied to zero.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   BOOT  | one cycle after reset: PC held, IF/ID bubble
//   RUN   | normal fetch: redirect > halt > independent PC / IF/ID update
//   HALT  | PC frozen, IF/ID bubble, halted=1; only rst leaves
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcwrite_hz,
  input  logic        ifidwrite_hz,
  input  logic        redirect_ex,
  input  logic [31:0] redirect_pc,
  input  logic        halt_id,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic        halted,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;

  // Next-state logic for the FSM, PC and IF/ID register
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    case (state_q)
      BOOT: begin
        state_d      = RUN;
        ifid_pc_d    = 32'h0;
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
      end
      RUN: begin
        if (redirect_ex) begin
          // The instruction in IF/ID is younger than the redirecting one,
          // so it is squashed even if decode is asking to halt on it.
          pc_d         = {redirect_pc[31:2], 2'b00};
          ifid_pc_d    = 32'h0;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end else if (halt_id && ifid_valid_q) begin
          state_d      = HALT;
          ifid_pc_d    = 32'h0;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end else begin
          if (pcwrite_hz) begin
            pc_d = pc_q + 32'd4;
          end
          if (ifidwrite_hz) begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = imem_rdata;
            ifid_valid_d = 1'b1;
          end
        end
      end
      HALT: begin
        ifid_pc_d    = 32'h0;
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
      end
      default: begin
        state_d      = BOOT;
        ifid_pc_d    = 32'h0;
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= 32'h0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign imem_addr  = pc_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_valid = ifid_valid_q;
  assign halted     = (state_q == HALT);

`ifdef PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Saturating stall counter: RUN cycles where the PC is held and not redirected
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'h0;
    end else if (state_q == RUN && !pcwrite_hz && !redirect_ex &&
                 stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  // Saturating redirect counter: RUN cycles with an EX redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt_q <= 32'h0;
    end else if (state_q == RUN && redirect_ex &&
                 flush_cnt_q != 32'hFFFF_FFFF) begin
      flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 32'h0;
  assign flush_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a table of directed vectors followed by
// hand-written multi-cycle sequences (long stall, bounded wait for halt).
module tb_fetch_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] MEMX = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rst, pcwrite_hz, ifidwrite_hz, redirect_ex, halt_id;
  logic [31:0] redirect_pc, imem_addr, imem_rdata;
  logic [31:0] ifid_pc, ifid_instr, stall_cnt, flush_cnt;
  logic        ifid_valid, halted;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  // Memory model: word content is derived from its address
  assign imem_rdata = imem_addr ^ MEMX;

  fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .pcwrite_hz(pcwrite_hz), .ifidwrite_hz(ifidwrite_hz),
    .redirect_ex(redirect_ex), .redirect_pc(redirect_pc), .halt_id(halt_id),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .ifid_pc(ifid_pc),
    .ifid_instr(ifid_instr), .ifid_valid(ifid_valid), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct {
    logic        rst, pcw, ifw, red;
    logic [31:0] rpc;
    logic        hlt;
    logic [31:0] e_addr, e_ifpc;
    logic        e_valid, e_halted;
    logic [31:0] e_stall, e_flush;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic r, logic pw, logic iw, logic rd, logic [31:0] rp,
                              logic h, logic [31:0] ea, logic [31:0] ep, logic ev,
                              logic eh, logic [31:0] es, logic [31:0] ef);
    vec_t v;
    v.rst = r; v.pcw = pw; v.ifw = iw; v.red = rd; v.rpc = rp; v.hlt = h;
    v.e_addr = ea; v.e_ifpc = ep; v.e_valid = ev; v.e_halted = eh;
`ifdef PERF_CNT_EN
    v.e_stall = es; v.e_flush = ef;
`else
    v.e_stall = 32'h0; v.e_flush = 32'h0;
    if (es == ef) v.e_stall = 32'h0;
`endif
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: actual %h, required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic r, logic pw, logic iw, logic rd, logic [31:0] rp, logic h);
    rst = r; pcwrite_hz = pw; ifidwrite_hz = iw; redirect_ex = rd;
    redirect_pc = rp; halt_id = h;
  endtask

  initial begin
    int budget;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

    //   rst pcw ifw red rpc            hlt addr           ifid_pc        v  h  stall flush
    add(1, 1, 1, 0, 32'h0,          0, 32'h0,          32'h0,          0, 0, 0, 0); // reset
    add(1, 1, 1, 0, 32'h0,          0, 32'h0,          32'h0,          0, 0, 0, 0);
    add(1, 1, 1, 0, 32'h0,          0, 32'h0,          32'h0,          0, 0, 0, 0);
    add(0, 1, 1, 0, 32'h0,          0, 32'h0,          32'h0,          0, 0, 0, 0); // BOOT edge
    add(0, 1, 1, 0, 32'h0,          0, 32'h4,          32'h0,          1, 0, 0, 0);
    add(0, 1, 1, 0, 32'h0,          0, 32'h8,          32'h4,          1, 0, 0, 0);
    add(0, 1, 1, 0, 32'h0,          0, 32'hC,          32'h8,          1, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0,          0, 32'hC,          32'h8,          1, 0, 1, 0); // load-use stall
    add(0, 1, 1, 0, 32'h0,          0, 32'h10,         32'hC,          1, 0, 1, 0);
    add(0, 1, 1, 0, 32'h0,          0, 32'h14,         32'h10,         1, 0, 1, 0);
    add(0, 0, 1, 1, 32'h103,        0, 32'h100,        32'h0,          0, 0, 1, 1); // redirect vs stall
    add(0, 1, 1, 0, 32'h0,          0, 32'h104,        32'h100,        1, 0, 1, 1);
    add(0, 0, 1, 0, 32'h0,          0, 32'h104,        32'h104,        1, 0, 2, 1); // PC held, IF/ID loads
    add(0, 1, 0, 0, 32'h0,          0, 32'h108,        32'h104,        1, 0, 2, 1); // PC moves, IF/ID held
    add(0, 1, 1, 0, 32'h0,          0, 32'h10C,        32'h108,        1, 0, 2, 1);
    add(0, 1, 1, 1, 32'hFFFF_FFFC,  1, 32'hFFFF_FFFC,  32'h0,          0, 0, 2, 2); // halt vs redirect
    add(0, 1, 1, 0, 32'h0,          1, 32'h0,          32'hFFFF_FFFC,  1, 0, 2, 2); // halt ignored, wrap
    add(0, 1, 1, 0, 32'h0,          0, 32'h4,          32'h0,          1, 0, 2, 2);
    add(0, 1, 1, 0, 32'h0,          1, 32'h4,          32'h0,          0, 1, 2, 2); // halt accepted
    add(0, 1, 1, 1, 32'h200,        0, 32'h4,          32'h0,          0, 1, 2, 2); // ignored in HALT
    add(0, 0, 0, 0, 32'h0,          1, 32'h4,          32'h0,          0, 1, 2, 2);
    add(1, 1, 1, 0, 32'h0,          0, 32'h0,          32'h0,          0, 0, 0, 0); // rst leaves HALT
    add(0, 1, 1, 1, 32'h40,         0, 32'h0,          32'h0,          0, 0, 0, 0); // redirect in BOOT
    add(0, 1, 1, 0, 32'h0,          0, 32'h4,          32'h0,          1, 0, 0, 0);
    add(1, 0, 0, 0, 32'h0,          0, 32'h0,          32'h0,          0, 0, 0, 0); // rst mid-stall

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].pcw, vecs[i].ifw, vecs[i].red, vecs[i].rpc, vecs[i].hlt);
      step();
      chk($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d ifid_pc", i), ifid_pc, vecs[i].e_ifpc);
      chk($sformatf("v%0d ifid_valid", i), {31'h0, ifid_valid}, {31'h0, vecs[i].e_valid});
      chk($sformatf("v%0d ifid_instr", i), ifid_instr,
          vecs[i].e_valid ? (vecs[i].e_ifpc ^ MEMX) : NOP);
      chk($sformatf("v%0d halted", i), {31'h0, halted}, {31'h0, vecs[i].e_halted});
      chk($sformatf("v%0d stall_cnt", i), stall_cnt, vecs[i].e_stall);
      chk($sformatf("v%0d flush_cnt", i), flush_cnt, vecs[i].e_flush);
    end

    // Multi-cycle stall: instruction at 8 re-presented with no loss or duplication
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    step();                                   // BOOT
    step(); step(); step();                   // ifid_pc 0,4,8
    chk("seq pre-stall ifid_pc", ifid_pc, 32'h8);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("seq stall%0d ifid_pc", k), ifid_pc, 32'h8);
      chk($sformatf("seq stall%0d imem_addr", k), imem_addr, 32'hC);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    step();
    chk("seq resume ifid_pc", ifid_pc, 32'hC);
    chk("seq resume ifid_instr", ifid_instr, 32'hC ^ MEMX);
    step();
    chk("seq resume2 ifid_pc", ifid_pc, 32'h10);
    chk("seq resume2 imem_addr", imem_addr, 32'h14);
`ifdef PERF_CNT_EN
    chk("seq stall_cnt", stall_cnt, 32'd3);
`else
    chk("seq stall_cnt", stall_cnt, 32'd0);
`endif

    // Halt with a bounded wait, then PC must stay frozen against later pulses
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    budget = 0;
    do begin
      step();
      budget++;
    end while (!halted && budget < 4);
    chk("seq halt latency", budget, 1);
    chk("seq halt addr", imem_addr, 32'h14);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h300, 1'b0);
    step();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    step();
    chk("seq halted frozen addr", imem_addr, 32'h14);
    chk("seq halted flag", {31'h0, halted}, 32'h1);
    chk("seq halted valid", {31'h0, ifid_valid}, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    step();
    chk("seq reset addr", imem_addr, 32'h0);
    chk("seq reset halted", {31'h0, halted}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Front end of the RV32I pipeline. Owns the program counter and the IF/ID pipeline register, and drives the instruction-memory address. It is the consumer of the hazard unit's stall handshake: it holds the PC and IF/ID when told to, squashes IF/ID on an EX-stage redirect, and freezes on a halt request from decode.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in IF/ID when it is invalid.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- pcwrite_hz  input  1  1 = PC may advance; 0 = hold PC.
- ifidwrite_hz  input  1  1 = IF/ID may load; 0 = hold IF/ID.
- redirect_ex  input  1  taken branch/jump resolved in EX.
- redirect_pc  input  32  target PC when redirect_ex=1.
- halt_id  input  1  ecall/ebreak decoded in ID.
- imem_addr  output  32  instruction fetch address; combinational copy of the PC register.
- imem_rdata  input  32  instruction word at imem_addr, same cycle (combinational memory).
- ifid_pc  output  32  PC of the instruction in IF/ID.
- ifid_instr  output  32  instruction in IF/ID.
- ifid_valid  output  1  IF/ID holds a real instruction.
- halted  output  1  core is in HALT.
- stall_cnt  output  32  stall-cycle counter (see Configuration).
- flush_cnt  output  32  redirect counter (see Configuration).

## Operation
- FSM states:
  - BOOT: entered on reset. Lasts exactly one cycle. PC is held and IF/ID gets a bubble. The FSM then moves to RUN.
  - RUN: normal fetch.
  - HALT: PC is frozen, IF/ID is a bubble, halted=1. Only rst leaves HALT.
- Reset values:
  - pc=RESET_PC, so imem_addr=RESET_PC.
  - ifid_pc=0, ifid_instr=NOP_INSTR, ifid_valid=0.
  - halted=0, stall_cnt=0, flush_cnt=0, state=BOOT.
- RUN, per edge, in priority order:
  1. redirect_ex=1:
     - pc ← {redirect_pc[31:2],2'b00}.
     - IF/ID ← bubble (ifid_instr=NOP_INSTR, ifid_valid=0, ifid_pc=0).
     - pcwrite_hz, ifidwrite_hz and halt_id are ignored. The ID instruction is younger and is squashed.
  2. halt_id=1 and ifid_valid=1:
     - State ← HALT, IF/ID ← bubble, pc held.
  3. Otherwise PC and IF/ID update independently:
     - PC: pcwrite_hz=1 gives pc ← pc+4; pcwrite_hz=0 holds pc.
     - IF/ID: ifidwrite_hz=1 gives ifid_pc ← pc, ifid_instr ← imem_rdata, ifid_valid ← 1; ifidwrite_hz=0 holds all three.
- halt_id while ifid_valid=0 is ignored.
- PC arithmetic is 32-bit unsigned and wraps modulo 2^32: 32'hFFFF_FFFC+4 = 0.
- In BOOT and HALT, redirect_ex, pcwrite_hz, ifidwrite_hz and halt_id are all ignored.

## Timing
- imem_addr follows the PC register with zero combinational delay. IF/ID captures imem_rdata at the same edge that advances the PC.
- Boot: rst is low at edge E0 → BOOT→RUN, pc still RESET_PC. At E1 IF/ID receives (RESET_PC, mem[RESET_PC]) and pc=RESET_PC+4.
- Stall: each cycle with both enables low holds the current instruction in IF/ID and keeps the same imem_addr. The stalled instruction is re-presented to ID with no loss or duplication.
- Redirect at edge N: imem_addr=target in cycle N+1. IF/ID is valid again from edge N+1. Redirect penalty is 2 bubbles (IF/ID bubble plus the wrongly fetched instruction already in ID, which ID/EX control squashes).
- halted rises at the edge after halt_id is accepted.
- rst high at any edge, including mid-stall, mid-redirect or in HALT, restores all reset values at that edge.

## Configuration
- PERF_CNT_EN defined:
  - stall_cnt increments on every RUN edge with pcwrite_hz=0 and redirect_ex=0.
  - flush_cnt increments on every RUN edge with redirect_ex=1.
  - Both counters saturate at 32'hFFFF_FFFF and clear on rst.
- PERF_CNT_EN undefined: both ports are tied to 0 and no counter flops are built. All other behaviour is identical.

## Test plan
- Boot: hold rst 3 cycles, release, memory returns pc-based words → ifid_valid=0 for 1 edge, then ifid_pc=0,4,8 on successive edges.
- Load-use stall: pcwrite_hz=ifidwrite_hz=0 for 1 cycle while ifid_pc=8 → ifid_pc stays 8 one extra cycle, imem_addr stays 12, then resumes 12,16. With PERF_CNT_EN, stall_cnt=1.
- Redirect vs stall: redirect_ex=1, redirect_pc=32'h0000_0103, pcwrite_hz=0 at the same edge → pc=32'h100, ifid_valid=0, next edge ifid_pc=32'h100. With PERF_CNT_EN, flush_cnt=1 and stall_cnt unchanged.
- Halt: halt_id=1 with ifid_valid=1 → halted=1 next edge, imem_addr frozen, later redirect_ex/pcwrite pulses have no effect. rst → pc=RESET_PC, halted=0.
- Halt vs redirect same edge → redirect taken, halted stays 0.
- Wrap: redirect to 32'hFFFF_FFFC, run 1 cycle → imem_addr=0.
